// File: rtl/fetch_pkg.sv
// Shared types for the risc1 instruction-fetch front end.
// Address width follows `ARCH_SIZE; a 16-bit default keeps the slice standalone.
`ifndef ARCH_SIZE
`define ARCH_SIZE 16
`endif

package fetch_pkg;

   localparam int ARCH_ADDR_W = `ARCH_SIZE;

   typedef logic [ARCH_ADDR_W-1:0] addr_t;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      RELEASE
   } fetch_state_e;

   typedef struct packed {
      logic [7:0] data;
      addr_t      pc;
   } queue_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO with slot reservation: count covers stored entries plus slots
// reserved for requests still in flight, so a granted response always fits.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int  QUEUE_DEPTH = 4,
   parameter type entry_t     = queue_entry_t,
   localparam int PTR_W       = $clog2(QUEUE_DEPTH)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           reserve,
   input  logic           push,
   input  entry_t         push_entry,
   input  logic           pop,
   input  logic           flush,
   output entry_t         head,
   output logic           full,
   output logic           empty,
   output logic [PTR_W:0] count
);

   entry_t           storage [QUEUE_DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W:0]   used;
   logic [PTR_W:0]   reserved;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of block ordering.
   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         used     <= '0;
         reserved <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         used     <= used + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
         reserved <= reserved + {{PTR_W{1'b0}}, reserve} - {{PTR_W{1'b0}}, push};
      end
   end

   // NOTE: the storage array has no reset; entries are only observed after a
   // push has written them, so clearing them would be wasted logic.
   always_ff @(posedge clk) begin
      if (push && !flush) storage[wr_ptr] <= push_entry;
   end

   assign head  = storage[rd_ptr];
   assign count = used + reserved;
   assign full  = (count == (PTR_W + 1)'(QUEUE_DEPTH));
   assign empty = (used == '0);

endmodule

// File: rtl/fetch_unit.sv
// risc1 fetch front end: one-byte reads under a level handshake into a prefetch
// queue, redirect flushes. Optional counters behind `define FETCH_STATS_EN.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int                ADDR_W      = ARCH_ADDR_W,
   parameter int                QUEUE_DEPTH = 4,
   parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              instr_valid,
   output logic [7:0]        instr_data,
   output logic [ADDR_W-1:0] instr_pc,
   input  logic              instr_ready,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_read,
   output logic              mem_write,
   output logic [7:0]        mem_write_value,
   input  logic              mem_ready,
   input  logic [7:0]        mem_read_value
`ifdef FETCH_STATS_EN
   ,
   output logic [31:0]       stat_fetched,
   output logic [31:0]       stat_stalls
`endif
);

   localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

   typedef struct packed {
      logic [7:0]        data;
      logic [ADDR_W-1:0] pc;
   } entry_t;

   fetch_state_e      state, state_n;
   logic [ADDR_W-1:0] fetch_pc, pc_n, addr_n;
   logic              read_n, drop, drop_n;
   logic              reserve, capture, pop;
   logic              q_full, q_empty;
   logic [CNT_W-1:0]  q_count;
   entry_t            head, held, push_entry;

   assign push_entry = '{data: mem_read_value, pc: mem_address};
   assign pop        = instr_valid && instr_ready;

   fetch_queue #(
      .QUEUE_DEPTH(QUEUE_DEPTH),
      .entry_t    (entry_t)
   ) u_queue (
      .clk       (clk),
      .rst_n     (rst_n),
      .reserve   (reserve),
      .push      (capture),
      .push_entry(push_entry),
      .pop       (pop),
      .flush     (redirect_valid),
      .head      (head),
      .full      (q_full),
      .empty     (q_empty),
      .count     (q_count)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         fetch_pc    <= RESET_PC;
         mem_address <= '0;
         mem_read    <= 1'b0;
         drop        <= 1'b0;
      end else begin
         state       <= state_n;
         fetch_pc    <= pc_n;
         mem_address <= addr_n;
         mem_read    <= read_n;
         drop        <= drop_n;
      end
   end

   // NOTE: every signal driven here gets a default first, so no path through
   // the case leaves one unassigned and no latch is inferred.
   always_comb begin
      state_n = state;
      pc_n    = fetch_pc;
      addr_n  = mem_address;
      read_n  = mem_read;
      drop_n  = drop;
      reserve = 1'b0;
      capture = 1'b0;
      unique case (state)
         IDLE: begin
            // A redirect this cycle would make the request use the stale PC.
            if (!redirect_valid && !q_full && !mem_ready) begin
               state_n = REQ;
               addr_n  = fetch_pc;
               read_n  = 1'b1;
               reserve = 1'b1;
            end
         end
         REQ: begin
            if (mem_ready) begin
               state_n = RELEASE;
               read_n  = 1'b0;
               drop_n  = 1'b0;
               if (!drop && !redirect_valid) begin
                  capture = 1'b1;
                  pc_n    = fetch_pc + ADDR_W'(1);
               end
            end else if (redirect_valid) begin
               drop_n = 1'b1;
            end
         end
         RELEASE: begin
            if (!mem_ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
      if (redirect_valid) pc_n = redirect_pc;
   end

   // Last head shown, so data/pc hold steady while the queue is empty.
   always_ff @(posedge clk) begin
      if (!rst_n)        held <= '0;
      else if (!q_empty) held <= head;
   end

   assign instr_valid     = !q_empty;
   assign instr_data      = q_empty ? held.data : head.data;
   assign instr_pc        = q_empty ? held.pc   : head.pc;
   assign mem_write       = 1'b0;
   assign mem_write_value = '0;

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      q_count <= CNT_W'(QUEUE_DEPTH));

`ifdef FETCH_STATS_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stat_fetched <= '0;
         stat_stalls  <= '0;
      end else begin
         if (capture && stat_fetched != '1) stat_fetched <= stat_fetched + 32'd1;
         if (state == REQ && !mem_ready && stat_stalls != '1)
            stat_stalls <= stat_stalls + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: byte-memory responder, stream model that
// expects consecutive bytes from the last reset/redirect PC, directed + random.
module tb_fetch_unit;

   localparam int            AW    = 16;
   localparam int            DEPTH = 4;
   localparam logic [AW-1:0] RPC   = '0;

   logic          clk, rst_n;
   logic          redirect_valid;
   logic [AW-1:0] redirect_pc;
   logic          instr_valid, instr_ready;
   logic [7:0]    instr_data;
   logic [AW-1:0] instr_pc;
   logic [AW-1:0] mem_address;
   logic          mem_read, mem_write, mem_ready;
   logic [7:0]    mem_write_value, mem_read_value;
`ifdef FETCH_STATS_EN
   logic [31:0]   stat_fetched, stat_stalls;
`endif

   fetch_unit #(.ADDR_W(AW), .QUEUE_DEPTH(DEPTH), .RESET_PC(RPC)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr_data     (instr_data),
      .instr_pc       (instr_pc),
      .instr_ready    (instr_ready),
      .mem_address    (mem_address),
      .mem_read       (mem_read),
      .mem_write      (mem_write),
      .mem_write_value(mem_write_value),
      .mem_ready      (mem_ready),
      .mem_read_value (mem_read_value)
`ifdef FETCH_STATS_EN
      ,
      .stat_fetched   (stat_fetched),
      .stat_stalls    (stat_stalls)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] pc;
      logic [7:0]    data;
   } xfer_t;

   typedef struct {
      int delay;
      int cycles;
   } lat_t;

   logic [7:0]    mem [0:(1<<AW)-1];
   int            errors, checks;
   int            mem_delay, wait_cnt;
   int            stall_cycles, xfers;
   logic [AW-1:0] exp_pc;
   logic [AW-1:0] issued[$];
   xfer_t         got[$];
   logic          prev_read, addr_moved, wr_seen;
   logic [AW-1:0] req_addr;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // One clock: capture pre-edge handshake, advance, then model + memory.
   task automatic cycle();
      logic          xfer, rd, in_reset;
      logic [7:0]    xd;
      logic [AW-1:0] xp, rp;
      in_reset = !rst_n;
      xfer     = instr_valid && instr_ready && rst_n;
      xd       = instr_data;
      xp       = instr_pc;
      rd       = redirect_valid && rst_n;
      rp       = redirect_pc;
      if (mem_read === 1'b1 && mem_ready === 1'b0) stall_cycles++;
      @(posedge clk);
      #1;
      if (in_reset) begin
         exp_pc = RPC;
      end else begin
         if (xfer) begin
            check("xfer_pc", 64'(xp), 64'(exp_pc));
            check("xfer_data", 64'(xd), 64'(mem[exp_pc]));
            got.push_back('{xp, xd});
            exp_pc = exp_pc + 1'b1;
            xfers++;
         end
         if (rd) begin
            exp_pc = rp;
            check("flush_valid", 64'(instr_valid), 64'd0);
         end
      end
      if (mem_write !== 1'b0 || mem_write_value !== 8'h00) wr_seen = 1'b1;
      if (mem_read === 1'b1 && !prev_read) begin
         issued.push_back(mem_address);
         req_addr = mem_address;
      end else if (mem_read === 1'b1 && mem_address !== req_addr) begin
         addr_moved = 1'b1;
      end
      prev_read = (mem_read === 1'b1);
      if (mem_read === 1'b1 && !mem_ready) begin
         if (wait_cnt >= mem_delay) begin
            mem_ready      = 1'b1;
            mem_read_value = mem[mem_address];
         end else begin
            wait_cnt++;
         end
      end else if (mem_read !== 1'b1) begin
         mem_ready = 1'b0;
         wait_cnt  = 0;
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic do_reset();
      rst_n          = 1'b0;
      redirect_valid = 1'b0;
      run(2);
      rst_n = 1'b1;
      issued.delete();
      got.delete();
      stall_cycles = 0;
      xfers        = 0;
      addr_moved   = 1'b0;
   endtask

   initial begin
      xfer_t tbl[4];
      lat_t  lat_tbl[3];
      int    n;
      logic  found;

      tbl[0] = '{16'd0, 8'h11};
      tbl[1] = '{16'd1, 8'h22};
      tbl[2] = '{16'd2, 8'h33};
      tbl[3] = '{16'd3, 8'h44};
      lat_tbl[0] = '{0, 2};
      lat_tbl[1] = '{2, 4};
      lat_tbl[2] = '{5, 7};

      errors = 0; checks = 0; wait_cnt = 0; mem_delay = 0;
      stall_cycles = 0; xfers = 0; exp_pc = RPC;
      prev_read = 1'b0; addr_moved = 1'b0; wr_seen = 1'b0; req_addr = '0;
      for (int i = 0; i < (1 << AW); i++) mem[i] = 8'($urandom);
      mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
      mem[102] = 8'd123;
      rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      instr_ready = 1'b0; mem_ready = 1'b0; mem_read_value = '0;

      // Reset state
      run(2);
      check("rst_instr_valid", 64'(instr_valid), 64'd0);
      check("rst_instr_data", 64'(instr_data), 64'd0);
      check("rst_instr_pc", 64'(instr_pc), 64'd0);
      check("rst_mem_address", 64'(mem_address), 64'd0);
      check("rst_mem_read", 64'(mem_read), 64'd0);
      check("rst_mem_write", 64'(mem_write), 64'd0);
      check("rst_mem_write_value", 64'(mem_write_value), 64'd0);

      // In-order stream from mem[0..3]
      do_reset();
      instr_ready = 1'b1;
      run(30);
      for (int i = 0; i < 4; i++) begin
         if (i < got.size()) begin
            check("table_pc", 64'(got[i].pc), 64'(tbl[i].pc));
            check("table_data", 64'(got[i].data), 64'(tbl[i].data));
         end else begin
            check("table_missing", 64'(got.size()), 64'(i + 1));
         end
      end

      // First-byte latency and hold-stable request versus memory delay
      for (int k = 0; k < 3; k++) begin
         mem_delay = lat_tbl[k].delay;
         do_reset();
         n = 0;
         while (!instr_valid && n < 50) begin
            cycle();
            n++;
         end
         check("latency", 64'(n), 64'(lat_tbl[k].cycles));
         check("stall_cycles", 64'(stall_cycles), 64'(lat_tbl[k].delay));
         check("addr_stable", 64'(addr_moved), 64'd0);
`ifdef FETCH_STATS_EN
         check("stat_stalls", 64'(stat_stalls), 64'(lat_tbl[k].delay));
         check("stat_fetched", 64'(stat_fetched), 64'd1);
`endif
      end

      // Backpressure: exactly DEPTH reads, then resume at DEPTH
      mem_delay   = 0;
      instr_ready = 1'b0;
      do_reset();
      run(60);
      check("full_reads", 64'(issued.size()), 64'(DEPTH));
      for (int i = 0; i < DEPTH && i < issued.size(); i++)
         check("full_addr", 64'(issued[i]), 64'(i));
      check("full_idle_read", 64'(mem_read), 64'd0);
      check("full_valid", 64'(instr_valid), 64'd1);
      issued.delete();
      instr_ready = 1'b1;
      run(20);
      check("resume_addr", 64'(issued.size() > 0 ? issued[0] : 16'hDEAD), 64'(DEPTH));

      // Redirect while REQ for address 5 waits on memory
      mem_delay = 3;
      do_reset();
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         cycle();
         found = (mem_read === 1'b1 && mem_address == 16'd5 && !mem_ready);
      end
      check("req5_reached", 64'(found), 64'd1);
      redirect_valid = 1'b1;
      redirect_pc    = 16'd102;
      cycle();
      redirect_valid = 1'b0;
      got.delete();
      run(40);
      check("redir_pc", 64'(got.size() > 0 ? got[0].pc : 16'hDEAD), 64'd102);
      check("redir_data", 64'(got.size() > 0 ? got[0].data : 8'h00), 64'd123);

      // PC wraps at the top of the address space
      redirect_valid = 1'b1;
      redirect_pc    = '1;
      cycle();
      redirect_valid = 1'b0;
      issued.delete();
      run(30);
      check("wrap_first", 64'(issued.size() > 0 ? issued[0] : 16'h0BAD), 64'hFFFF);
      check("wrap_next", 64'(issued.size() > 1 ? issued[1] : 16'h0BAD), 64'h0000);

      // Reset in the middle of a request
      mem_delay   = 0;
      instr_ready = 1'b0;
      do_reset();
      n = 0;
      while (!instr_valid && n < 50) begin cycle(); n++; end
      mem_delay = 10;
      n = 0;
      while (!(mem_read === 1'b1 && !mem_ready) && n < 50) begin cycle(); n++; end
      check("midreq_reached", 64'(mem_read), 64'd1);
      cycle();
      rst_n = 1'b0;
      cycle();
      check("midreq_rst_read", 64'(mem_read), 64'd0);
      check("midreq_rst_valid", 64'(instr_valid), 64'd0);
      rst_n = 1'b1;
      issued.delete();
      run(10);
      check("midreq_restart", 64'(issued.size() > 0 ? issued[0] : 16'hDEAD), 64'(RPC));

      // Random ready, redirects and memory delays against the stream model
      mem_delay = 0;
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         instr_ready    = ($urandom_range(0, 3) != 0);
         redirect_valid = ($urandom_range(0, 31) == 0);
         redirect_pc    = AW'($urandom);
         if ($urandom_range(0, 15) == 0) mem_delay = $urandom_range(0, 4);
         cycle();
      end
      redirect_valid = 1'b0;
      check("rand_progress", 64'(xfers > 100), 64'd1);
`ifdef FETCH_STATS_EN
      check("rand_stat_stalls", 64'(stat_stalls), 64'(stall_cycles));
`endif
      check("never_writes", 64'(wr_seen), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
